uart: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx.sv | 100 ++++++++++
 rtl/uart.sv | 142 ++++++++++++++
 tb/tb_uart.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states and frame constants for the loopback UART
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 10;
   localparam int DATA_BITS = 8;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT = 1'b1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serialiser; every bit held for exactly CLKS_PER_BIT cycles
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       serial_o,
   output logic       busy_o,
   output logic [7:0] byte_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   tx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       byte_q, byte_d;
   logic             line_q, line_d;
   logic             bit_done;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         byte_q  <= '0;
         line_q  <= STOP_BIT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         byte_q  <= byte_d;
         line_q  <= line_d;
      end
   end

   assign bit_done = (cnt_q == CNT_LAST);

   // The line is registered, so the next bit value is chosen on the bit boundary.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      byte_d  = byte_q;
      line_d  = line_q;
      case (state_q)
         TX_IDLE: begin
            if (start_i) begin
               state_d = TX_START;
               byte_d  = data_i;
               cnt_d   = '0;
               line_d  = START_BIT;
            end
         end
         TX_START: begin
            if (bit_done) begin
               state_d = TX_DATA;
               cnt_d   = '0;
               idx_d   = '0;
               line_d  = byte_q[0];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (bit_done) begin
               cnt_d = '0;
               if (idx_q == 3'(DATA_BITS - 1)) begin
                  state_d = TX_STOP;
                  line_d  = STOP_BIT;
               end else begin
                  idx_d  = idx_q + 3'd1;
                  line_d = byte_q[idx_d];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TX_STOP: begin
            if (bit_done) begin
               state_d = TX_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   assign serial_o = line_q;
   assign busy_o   = (state_q != TX_IDLE);
   assign byte_o   = byte_q;

endmodule

// File: rtl/uart.sv
// rtl/uart.sv - loopback 8N1 endpoint: synchronised receiver, one-entry pending buffer, echo transmitter
module uart
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       serial_rx,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       serial_tx,
   output logic [7:0] tx_byte,
   output logic       tx_busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic             sync1_q, rx_s_q;
   rx_state_t        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_idx_q, rx_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             rx_valid_q, rx_valid_d;
   logic             pend_q, pend_d;
   logic [7:0]       pend_byte_q, pend_byte_d;
   logic             tx_start;
   logic [7:0]       tx_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_idx_q    <= '0;
         shift_q     <= '0;
         rx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         pend_q      <= 1'b0;
         pend_byte_q <= '0;
      end else begin
         sync1_q     <= serial_rx;
         rx_s_q      <= sync1_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_idx_q    <= rx_idx_d;
         shift_q     <= shift_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         pend_q      <= pend_d;
         pend_byte_q <= pend_byte_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      shift_d    = shift_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_s_q == START_BIT) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         // Mid-bit recheck of the start bit rejects short glitches.
         RX_START: begin
            if (rx_cnt_q == CNT_HALF) begin
               rx_cnt_d = '0;
               rx_idx_d = '0;
               rx_state_d = (rx_s_q == START_BIT) ? RX_DATA : RX_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d          = '0;
               shift_d[rx_idx_q] = rx_s_q;
               if (rx_idx_q == 3'(DATA_BITS - 1)) rx_state_d = RX_STOP;
               else rx_idx_d = rx_idx_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d = '0;
               if (rx_s_q == STOP_BIT) begin
                  rx_byte_d  = shift_q;
                  rx_valid_d = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_WAIT_IDLE;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_WAIT_IDLE: begin
            if (rx_s_q == STOP_BIT) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // A pending byte always goes out before a freshly received one, which then waits in the buffer.
   assign tx_start = !tx_busy && (pend_q || rx_valid_q);
   assign tx_data  = pend_q ? pend_byte_q : rx_byte_q;

   always_comb begin
      pend_d      = pend_q;
      pend_byte_d = pend_byte_q;
      if (rx_valid_q && (tx_busy || pend_q)) begin
         pend_d      = 1'b1;
         pend_byte_d = rx_byte_q;
      end else if (tx_start) begin
         pend_d = 1'b0;
      end
   end

   uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clock_i (clock),
      .reset_i (reset),
      .start_i (tx_start),
      .data_i  (tx_data),
      .serial_o(serial_tx),
      .busy_o  (tx_busy),
      .byte_o  (tx_byte)
   );

   assign rx_byte  = rx_byte_q;
   assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - directed scoreboard bench for the loopback UART
`timescale 1ns/1ps
module tb_uart;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       serial_rx = 1'b1;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       serial_tx;
   logic [7:0] tx_byte;
   logic       tx_busy;

   uart #(.CLKS_PER_BIT(10)) dut (
      .clock    (clock),
      .reset    (reset),
      .serial_rx(serial_rx),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .serial_tx(serial_tx),
      .tx_byte  (tx_byte),
      .tx_busy  (tx_busy)
   );

   always #10 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] rx_exp[$];
   logic [7:0] tx_exp[$];
   int         tx_start_q[$];
   int         rx_count = 0;
   int         tx_frames = 0;
   int         last_rv_cyc = 0;
   bit         mon_act = 0;
   int         mon_k = 0;
   logic [9:0] mon_bits = '0;
   bit         mon_busy_ok = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && rx_valid === 1'b1) begin
         rx_count++;
         last_rv_cyc = cyc;
         if (rx_exp.size() == 0) chk("rx_unexpected_valid", rx_exp.size(), 1);
         else chk("rx_byte", rx_byte, rx_exp.pop_front());
      end
   end

   always @(negedge clock) begin
      if (reset) begin
         mon_act = 0;
      end else if (!mon_act) begin
         if (serial_tx === 1'b0) begin
            mon_act     = 1;
            mon_k       = 0;
            mon_busy_ok = (tx_busy === 1'b1);
            tx_start_q.push_back(cyc);
         end
      end else begin
         mon_k++;
         if (mon_k % 10 == 5) begin
            mon_bits[mon_k / 10] = serial_tx;
            if (tx_busy !== 1'b1) mon_busy_ok = 0;
         end
         if (mon_k == 95) begin
            mon_act = 0;
            tx_frames++;
            chk("tx_start_bit", mon_bits[0], 0);
            chk("tx_stop_bit", mon_bits[9], 1);
            chk("tx_busy_in_frame", mon_busy_ok, 1);
            if (tx_exp.size() == 0) chk("tx_unexpected_frame", tx_exp.size(), 1);
            else begin
               logic [7:0] e;
               e = tx_exp.pop_front();
               chk("tx_data", mon_bits[8:1], e);
               chk("tx_byte", tx_byte, e);
            end
         end
      end
   end

   task automatic align();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      serial_rx = 1'b0;
      #200;
      for (int i = 0; i < 8; i++) begin
         serial_rx = b[i];
         #200;
      end
      serial_rx = stop;
      #200;
   endtask

   task automatic expect_byte(input logic [7:0] b);
      rx_exp.push_back(b);
      tx_exp.push_back(b);
   endtask

   task automatic wait_rx(input int n, input int budget);
      for (int i = 0; i < budget && rx_count < n; i++) @(posedge clock);
      chk("rx_wait", rx_count >= n, 1);
   endtask

   task automatic wait_tx(input int n, input int budget);
      for (int i = 0; i < budget && tx_frames < n; i++) @(posedge clock);
      chk("tx_wait", tx_frames >= n, 1);
   endtask

   initial begin
      int c0;
      int ts;

      repeat (3) @(posedge clock);
      #1;
      chk("reset_serial_tx", serial_tx, 1);
      chk("reset_rx_byte", rx_byte, 8'h00);
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_tx_byte", tx_byte, 8'h00);
      chk("reset_tx_busy", tx_busy, 0);
      reset = 1'b0;
      repeat (50) align();
      chk("idle_serial_tx", serial_tx, 1);
      chk("idle_rx_byte", rx_byte, 8'h00);
      chk("idle_tx_busy", tx_busy, 0);
      chk("idle_rx_count", rx_count, 0);

      // Single byte 0x35 with latency checks
      c0 = cyc;
      expect_byte(8'h35);
      send_byte(8'h35, 1'b1);
      serial_rx = 1'b1;
      wait_rx(1, 200);
      chk("rx_latency_in_range", (last_rv_cyc - c0 >= 97) && (last_rv_cyc - c0 <= 98), 1);
      wait_tx(1, 300);
      ts = (tx_start_q.size() > 0) ? tx_start_q[0] : -1000;
      chk("tx_latency", ts - last_rv_cyc, 1);

      // Three-cycle glitch
      repeat (20) align();
      serial_rx = 1'b0;
      repeat (3) align();
      serial_rx = 1'b1;
      repeat (60) align();
      chk("glitch_rx_count", rx_count, 1);
      chk("glitch_tx_frames", tx_frames, 1);
      chk("glitch_serial_tx", serial_tx, 1);
      chk("glitch_tx_busy", tx_busy, 0);

      // Framing error then a good byte
      align();
      send_byte(8'hA5, 1'b0);
      serial_rx = 1'b1;
      repeat (20) align();
      chk("framing_rx_count", rx_count, 1);
      chk("framing_rx_byte_held", rx_byte, 8'h35);
      expect_byte(8'h3C);
      send_byte(8'h3C, 1'b1);
      serial_rx = 1'b1;
      wait_rx(2, 200);
      wait_tx(2, 300);

      // Back-to-back frames exercise the pending buffer
      repeat (20) align();
      tx_start_q.delete();
      expect_byte(8'h12);
      expect_byte(8'h34);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      serial_rx = 1'b1;
      wait_rx(4, 300);
      wait_tx(4, 400);
      chk("b2b_frame_starts", tx_start_q.size(), 2);
      if (tx_start_q.size() == 2) chk("b2b_start_spacing", tx_start_q[1] - tx_start_q[0], 101);

      // Reset during TX data bit 4 of 0x0F (a low bit)
      repeat (20) align();
      expect_byte(8'h0F);
      send_byte(8'h0F, 1'b1);
      serial_rx = 1'b1;
      for (int i = 0; i < 200 && tx_busy !== 1'b1; i++) align();
      chk("midreset_tx_started", tx_busy, 1);
      repeat (55) align();
      chk("midreset_bit4_low", serial_tx, 0);
      reset = 1'b1;
      #1;
      chk("midreset_serial_tx_high", serial_tx, 1);
      chk("midreset_tx_busy", tx_busy, 0);
      rx_exp.delete();
      tx_exp.delete();
      repeat (3) align();
      reset = 1'b0;
      repeat (200) align();
      chk("after_reset_serial_tx", serial_tx, 1);
      chk("after_reset_tx_busy", tx_busy, 0);
      chk("after_reset_no_frame", tx_frames, 4);
      chk("after_reset_rx_byte", rx_byte, 8'h00);
      chk("after_reset_tx_byte", tx_byte, 8'h00);

      chk("rx_queue_drained", rx_exp.size(), 0);
      chk("tx_queue_drained", tx_exp.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
